// File: rtl/hispe_pkg.sv
// Shared widths and types for the HiSPE datapath.
// The CPA split defaults to half the mantissa width.
package hispe_pkg;
    localparam int MANT_W    = 24;
    localparam int CPA_SPLIT = MANT_W / 2;

    typedef logic [MANT_W+1:0] psum_t;
endpackage

// File: rtl/cpa_segment.sv
// Combinational N-bit adder segment with carry in and carry out.
// Synthesis is free to map the '+' onto a prefix structure.
module cpa_segment #(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end

endmodule

// File: rtl/cpa_pipe_final_adder.sv
// Two-stage pipelined final adder: resolves {sum, carry<<1} into one binary word.
// Low H bits are added in stage 1; the high part plus stage-1 carry in stage 2.
module cpa_pipe_final_adder
    import hispe_pkg::*;
#(
    parameter int W = MANT_W,
    parameter int H = CPA_SPLIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] sum_i,
    input  logic [W-1:0] carry_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] result_o
);

    localparam int HW = W + 2 - H;
    localparam int LW = W - H;
    localparam int CW = W + 1 - H;

    logic [W:0]    cs;
    logic [H-1:0]  lo_sum;
    logic          lo_cout;
    logic [HW-1:0] hi_sum;
    logic          hi_cout_unused;

    logic          v1_q, v1_d, v2_q, v2_d;
    logic [H-1:0]  lo_q, lo_d;
    logic          c1_q, c1_d;
    logic [LW-1:0] sum_hi_q, sum_hi_d;
    logic [CW-1:0] cs_hi_q, cs_hi_d;
    logic [W+1:0]  res_q, res_d;
    logic          adv2, accept;

    assign cs = {carry_i, 1'b0};

    cpa_segment #(.N(H)) u_seg_lo (
        .a    (sum_i[H-1:0]),
        .b    (cs[H-1:0]),
        .cin  (1'b0),
        .s    (lo_sum),
        .cout (lo_cout)
    );

    cpa_segment #(.N(HW)) u_seg_hi (
        .a    ({2'b00, sum_hi_q}),
        .b    ({1'b0, cs_hi_q}),
        .cin  (c1_q),
        .s    (hi_sum),
        .cout (hi_cout_unused)
    );

    // Data regs load only on a real transfer, so don't-care inputs never propagate.
    always_comb begin
        adv2     = v1_q & (~v2_q | out_ready);
        in_ready = ~v1_q | adv2;
        accept   = in_valid & in_ready;

        v1_d     = v1_q;
        v2_d     = v2_q;
        lo_d     = lo_q;
        c1_d     = c1_q;
        sum_hi_d = sum_hi_q;
        cs_hi_d  = cs_hi_q;
        res_d    = res_q;

        if (accept) begin
            v1_d     = 1'b1;
            lo_d     = lo_sum;
            c1_d     = lo_cout;
            sum_hi_d = sum_i[W-1:H];
            cs_hi_d  = cs[W:H];
        end else if (adv2) begin
            v1_d = 1'b0;
        end

        if (adv2) begin
            v2_d  = 1'b1;
            res_d = {hi_sum, lo_q};
        end else if (out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            lo_q     <= '0;
            c1_q     <= 1'b0;
            sum_hi_q <= '0;
            cs_hi_q  <= '0;
            res_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            lo_q     <= lo_d;
            c1_q     <= c1_d;
            sum_hi_q <= sum_hi_d;
            cs_hi_q  <= cs_hi_d;
            res_q    <= res_d;
        end
    end

    assign out_valid = v2_q;
    assign result_o  = res_q;

endmodule

// File: tb/tb_cpa_pipe_final_adder.sv
// Self-checking bench for cpa_pipe_final_adder: directed sums, backpressure,
// streaming and mid-operation reset, with a queue-based reference scoreboard.
module tb_cpa_pipe_final_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] sum_i;
    logic [23:0] carry_i;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] result_o;

    int n_vec = 0;
    int n_err = 0;
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    cpa_pipe_final_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_i     (sum_i),
        .carry_i   (carry_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o)
    );

    function automatic logic [25:0] ref_sum(input logic [23:0] s, input logic [23:0] c);
        return {2'b00, s} + {1'b0, c, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        sum_i = 24'($urandom); carry_i = 24'($urandom);
        step(); step(); step();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (result_o !== 26'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", result_o); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ignored_input: got %b want 0", out_valid); end
        end
    endtask

    logic [23:0] dir_s [3] = '{24'h000001, 24'h000FFF, 24'hFFFFFF};
    logic [23:0] dir_c [3] = '{24'h000001, 24'h000001, 24'hFFFFFF};
    logic [25:0] dir_r [3] = '{26'h0000003, 26'h0001001, 26'h2FFFFFD};

    task automatic test_directed();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sum_i = dir_s[i]; carry_i = dir_c[i]; out_ready = 1'b1;
            #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
            step();
            in_valid = 1'b0; sum_i = 24'($urandom); carry_i = 24'($urandom);
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_latency1[%0d]: got %b want 0", i, out_valid); end
            step();
            #1;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir_latency2[%0d]: got %b want 1", i, out_valid); end
            n_vec++; if (result_o !== dir_r[i]) begin n_err++; $display("FAIL dir_result[%0d]: got %h want %h", i, result_o, dir_r[i]); end
            step();
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_drain[%0d]: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] stim [3];
        logic [25:0] exp_v;
        int sent = 0;
        int got  = 0;
        stim[0] = 24'd1; stim[1] = 24'd2; stim[2] = 24'd3;
        exp_q.delete();
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (sent < 3);
            sum_i     = (sent < 3) ? stim[sent] : 24'($urandom);
            carry_i   = (sent < 3) ? 24'h0 : 24'($urandom);
            #1;
            if (cyc == 2) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
                n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
            end
            if (cyc >= 2 && cyc < 4) begin
                n_vec++; if (result_o !== 26'd1) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want 1", cyc, result_o); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(sum_i, carry_i));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra_output: got %h want none", result_o);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (result_o !== exp_v) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", got, result_o, exp_v); end
                end
                got++;
            end
            step();
        end
        n_vec++; if (got != 3 || sent != 3) begin n_err++; $display("FAIL bp_count: got %0d out/%0d in want 3/3", got, sent); end
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [25:0] exp_v;
        int sent = 0;
        int got  = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && got < 100; cyc++) begin
            in_valid = (sent < 100);
            sum_i    = 24'($urandom);
            carry_i  = 24'($urandom);
            #1;
            if (sent < 100) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", cyc, in_ready); end
            end
            if (cyc >= 2 && cyc < 102) begin
                n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_rate[%0d]: got %b want 1", cyc, out_valid); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(sum_i, carry_i));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_extra_output: got %h want none", result_o);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (result_o !== exp_v) begin n_err++; $display("FAIL stream_result[%0d]: got %h want %h", got, result_o, exp_v); end
                end
                got++;
            end
            step();
        end
        n_vec++; if (got != 100) begin n_err++; $display("FAIL stream_count: got %0d want 100", got); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        in_valid = 1'b1; sum_i = 24'd5; carry_i = 24'd1;
        step();
        sum_i = 24'd7; carry_i = 24'd2;
        step();
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_loaded: got %b want 1", out_valid); end
        rst = 1'b1; in_valid = 1'b1; sum_i = 24'($urandom); carry_i = 24'($urandom);
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        n_vec++; if (result_o !== 26'h0) begin n_err++; $display("FAIL rm_result: got %h want 0", result_o); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_stale[%0d]: got %b want 0", i, out_valid); end
        end
        in_valid = 1'b1; sum_i = 24'h123456; carry_i = 24'h00ABCD;
        step();
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_latency1: got %b want 0", out_valid); end
        step();
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_latency2: got %b want 1", out_valid); end
        n_vec++; if (result_o !== 26'h0138BF0) begin n_err++; $display("FAIL rm_result_new: got %h want 0138bf0", result_o); end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sum_i = '0; carry_i = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
